// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, queue entry type and counter sizing for the
// instruction-fetch front end.
package fetch_pkg;
    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;
    localparam int DEPTH_DEF   = 4;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetched {pc, instr} entries with flush,
// occupancy count and a combinational head output.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = $bits(fetch_entry_t),
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is qualified by count in the parent.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC, issues pipelined imem reads under a
// credit limit, discards stale returns after redirect and queues the rest for decode.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic               stall_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic [PC_W-1:0]    next_pc_o
);
    localparam int              CW   = cnt_w(DEPTH);
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic            running;
    logic [PC_W-1:0] fetch_pc, resp_pc;
    logic [CW-1:0]   inflight, inflight_nxt, drop, count;
    logic            gnt_fire, ret, push, pop;
    entry_t          head, din;

    // Credit counts both outstanding reads and queued entries, so a return
    // always finds room in the queue.
    assign imem_req_o   = running && (({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH));
    assign imem_addr_o  = fetch_pc;
    assign gnt_fire     = imem_req_o && imem_gnt_i;
    assign ret          = imem_rvalid_i && (inflight != '0);
    assign push         = ret && (drop == '0) && !redirect_i;
    assign pop          = instr_valid_o && !stall_i && !redirect_i;
    assign inflight_nxt = inflight + CW'(gnt_fire) - CW'(ret);
    assign din          = '{pc: resp_pc, instr: imem_rdata_i};

    assign instr_valid_o = count != '0;
    assign instr_o       = instr_valid_o ? head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? head.pc : RESET_PC;
    assign next_pc_o     = instr_pc_o + STEP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            running  <= 1'b0;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            running  <= 1'b1;
            inflight <= inflight_nxt;
            // Every read still outstanding after a redirect is stale.
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
                resp_pc  <= redirect_pc_i;
                drop     <= inflight_nxt;
            end else begin
                if (gnt_fire) fetch_pc <= fetch_pc + STEP;
                if (push) resp_pc <= resp_pc + STEP;
                if (ret && drop != '0) drop <= drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );

    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_i)
        (imem_rvalid_i && running) |-> (inflight != '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        (push && !pop) |-> (count < CW'(DEPTH)));
endmodule
